// File: rtl/gshare_branch_predictor_pkg.sv
// gshare_branch_predictor_pkg: counter/state types and saturating counter update
package gshare_branch_predictor_pkg;

    typedef enum logic [1:0] {SNT, WNT, WT, ST} bp_ctr_t;
    typedef enum logic {BP_INIT, BP_RUN} bp_state_t;

    function automatic bp_ctr_t bp_ctr_next(bp_ctr_t c, logic taken);
        return taken ? ((c == ST) ? ST : bp_ctr_t'(c + 2'd1))
                     : ((c == SNT) ? SNT : bp_ctr_t'(c - 2'd1));
    endfunction

endpackage

// File: rtl/gshare_branch_predictor_pht.sv
// gshare_branch_predictor_pht: 2-bit counter table, sync read port, read-modify-write port
module gshare_branch_predictor_pht
    import gshare_branch_predictor_pkg::*;
#(
    parameter int ENTRIES = 256,
    localparam int IDX_W = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rd_en,
    input  logic [IDX_W-1:0] rd_addr,
    output bp_ctr_t          rd_ctr,
    input  logic             wr_en,
    input  logic             wr_init,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic             wr_taken
);

    bp_ctr_t mem [ENTRIES];

    // read returns the pre-write counter on an address collision
    always_ff @(posedge clk) begin
        if (rd_en) rd_ctr <= mem[rd_addr];
        if (wr_en) mem[wr_addr] <= wr_init ? WNT : bp_ctr_next(mem[wr_addr], wr_taken);
    end

endmodule

// File: rtl/gshare_branch_predictor.sv
// gshare_branch_predictor: gshare direction predictor with speculative GHR and mispredict repair
module gshare_branch_predictor
    import gshare_branch_predictor_pkg::*;
#(
    parameter int PHT_ENTRIES = 256,
    parameter int GHR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pred_req,
    input  logic [31:0]      pred_pc,
    output logic             pred_ready,
    output logic             pred_valid,
    output logic             pred_taken,
    output logic [GHR_W-1:0] pred_ghr,
    input  logic             upd_valid,
    input  logic [31:0]      upd_pc,
    input  logic [GHR_W-1:0] upd_ghr,
    input  logic             upd_taken,
    input  logic             upd_mispredict
);

    localparam int IDX_W = $clog2(PHT_ENTRIES);

    bp_state_t        state;
    logic [IDX_W-1:0] init_idx;
    logic [GHR_W-1:0] ghr, ghr_next;
    logic             valid_q, accept, upd_ok, repair;
    bp_ctr_t          rd_ctr;
    logic             unused_bits;

    function automatic logic [IDX_W-1:0] bp_idx(input logic [IDX_W-1:0] pc_bits, input logic [GHR_W-1:0] h);
        return pc_bits ^ IDX_W'(h);
    endfunction

    assign pred_ready  = (state == BP_RUN);
    assign accept      = pred_req & pred_ready;
    assign upd_ok      = upd_valid & pred_ready;
    assign repair      = upd_ok & upd_mispredict;
    assign pred_valid  = valid_q & ~repair;
    assign pred_taken  = pred_valid & rd_ctr[1];
    assign unused_bits = ^{pred_pc[31:IDX_W+1], pred_pc[0], upd_pc[31:IDX_W+1], upd_pc[0], rd_ctr[0]};

    gshare_branch_predictor_pht #(.ENTRIES(PHT_ENTRIES)) u_pht (
        .clk      (clk),
        .rd_en    (accept),
        .rd_addr  (bp_idx(pred_pc[IDX_W:1], ghr)),
        .rd_ctr   (rd_ctr),
        .wr_en    (~pred_ready | upd_ok),
        .wr_init  (~pred_ready),
        .wr_addr  (pred_ready ? bp_idx(upd_pc[IDX_W:1], upd_ghr) : init_idx),
        .wr_taken (upd_taken)
    );

    // repair from the resolved branch beats the speculative shift of a live prediction
    always_comb begin
        ghr_next = repair ? GHR_W'({upd_ghr, upd_taken}) : pred_valid ? GHR_W'({ghr, pred_taken}) : ghr;
    end

    // init sweep, history and prediction result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= BP_INIT;
            init_idx <= '0;
            ghr      <= '0;
            valid_q  <= 1'b0;
            pred_ghr <= '0;
        end else begin
            valid_q <= accept;
            ghr     <= ghr_next;
            if (accept) pred_ghr <= ghr;
            if (state == BP_INIT) begin
                init_idx <= init_idx + 1'b1;
                if (init_idx == IDX_W'(PHT_ENTRIES - 1)) state <= BP_RUN;
            end
        end
    end

endmodule

// File: tb/tb_gshare_branch_predictor.sv
// tb_gshare_branch_predictor: scoreboard bench for the gshare predictor
module tb_gshare_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic        pred_req;
    logic [31:0] pred_pc;
    logic        pred_ready, pred_valid, pred_taken;
    logic [7:0]  pred_ghr;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [7:0]  upd_ghr;
    logic        upd_taken, upd_mispredict;

    typedef struct packed {
        logic       t;
        logic [7:0] g;
    } exp_t;

    int         checks = 0;
    int         failures = 0;
    logic [1:0] m_pht [256];
    logic [7:0] m_ghr;
    exp_t       sb [$];
    logic       obs_v, obs_t;
    logic [7:0] obs_g;

    always #5 clk = ~clk;

    gshare_branch_predictor #(.PHT_ENTRIES(256), .GHR_W(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .pred_req       (pred_req),
        .pred_pc        (pred_pc),
        .pred_ready     (pred_ready),
        .pred_valid     (pred_valid),
        .pred_taken     (pred_taken),
        .pred_ghr       (pred_ghr),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_ghr        (upd_ghr),
        .upd_taken      (upd_taken),
        .upd_mispredict (upd_mispredict)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] idx(input logic [31:0] pc, input logic [7:0] g);
        return pc[8:1] ^ g;
    endfunction

    function automatic logic [1:0] sat(input logic [1:0] c, input logic t);
        return t ? ((c == 2'd3) ? 2'd3 : c + 2'd1) : ((c == 2'd0) ? 2'd0 : c - 2'd1);
    endfunction

    task automatic do_reset();
        int n;
        pred_req = 0; pred_pc = 0; upd_valid = 0; upd_pc = 0; upd_ghr = 0; upd_taken = 0; upd_mispredict = 0;
        rst = 1;
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        check("rst_ready", pred_ready, 0);
        check("rst_valid", pred_valid, 0);
        check("rst_taken", pred_taken, 0);
        check("rst_ghr", pred_ghr, 0);
        for (int i = 0; i < 256; i++) m_pht[i] = 2'd1;
        m_ghr = 0;
        sb.delete();
        n = 0;
        while (!pred_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("init_cycles", n, 256);
    endtask

    task automatic step(input logic req, input logic [31:0] pc, input logic uv, input logic [31:0] upc,
                        input logic [7:0] ug, input logic ut, input logic um);
        exp_t       e;
        logic       had, rep;
        logic [7:0] n_ghr;
        pred_req = req; pred_pc = pc; upd_valid = uv; upd_pc = upc; upd_ghr = ug; upd_taken = ut; upd_mispredict = um;
        #1;
        obs_v = pred_valid; obs_t = pred_taken; obs_g = pred_ghr;
        rep = uv & um;
        had = 0;
        e = '0;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (rep) check("drop_valid", pred_valid, 0);
            else begin
                had = 1;
                check("valid", pred_valid, 1);
                check("taken", pred_taken, e.t);
                check("ghr", pred_ghr, e.g);
            end
        end else check("idle_valid", pred_valid, 0);
        n_ghr = rep ? {ug[6:0], ut} : had ? {m_ghr[6:0], e.t} : m_ghr;
        if (req) sb.push_back('{t: m_pht[idx(pc, m_ghr)][1], g: m_ghr});
        if (uv) m_pht[idx(upc, ug)] = sat(m_pht[idx(upc, ug)], ut);
        m_ghr = n_ghr;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic upd(input logic [31:0] pc, input logic [7:0] g, input logic t, input logic m);
        step(0, 0, 1, pc, g, t, m);
    endtask

    task automatic zero_ghr();
        upd(32'h0F0, 8'h00, 0, 1);
    endtask

    task automatic predict(input logic [31:0] pc);
        step(1, pc, 0, 0, 0, 0, 0);
        idle();
    endtask

    initial begin
        rst = 1;
        @(negedge clk);
        do_reset();

        predict(32'h100);
        check("first_valid", obs_v, 1);
        check("first_taken", obs_t, 0);
        check("first_ghr", obs_g, 0);

        upd(32'h100, 8'h00, 1, 1);
        upd(32'h100, 8'h00, 1, 0);
        zero_ghr();
        predict(32'h100);
        check("train_st", obs_t, 1);
        upd(32'h100, 8'h00, 1, 0);
        upd(32'h100, 8'h00, 0, 0);
        zero_ghr();
        predict(32'h100);
        check("wt_taken", obs_t, 1);

        repeat (3) upd(32'h200, 8'h00, 0, 0);
        zero_ghr();
        predict(32'h200);
        check("snt_taken", obs_t, 0);
        upd(32'h200, 8'h00, 0, 0);
        upd(32'h200, 8'h00, 1, 0);
        zero_ghr();
        predict(32'h200);
        check("sat_lo", obs_t, 0);

        zero_ghr();
        step(1, 32'h0A0, 1, 32'h0A0, 8'h00, 1, 0);
        step(1, 32'h0A0, 0, 0, 0, 0, 0);
        check("coll_old", obs_t, 0);
        idle();
        check("coll_new", obs_t, 1);

        step(1, 32'h100, 0, 0, 0, 0, 0);
        upd(32'h0F0, 8'hA5, 0, 1);
        check("rep_drop", obs_v, 0);
        predict(32'h100);
        check("rep_ghr", obs_g, 8'h4A);

        for (int i = 0; i < 300; i++) begin
            logic uv;
            uv = ($urandom_range(0, 2) == 0);
            step(1'($urandom), 32'($urandom_range(0, 511)), uv, 32'($urandom_range(0, 511)),
                 8'($urandom), 1'($urandom), uv & ($urandom_range(0, 3) == 0));
        end
        idle();

        upd(32'h100, 8'h00, 1, 0);
        upd(32'h100, 8'h00, 1, 0);
        upd(32'h100, 8'h00, 1, 0);
        zero_ghr();
        predict(32'h100);
        check("pre_rst_st", obs_t, 1);
        pred_req = 1; pred_pc = 32'h100;
        @(posedge clk);
        @(negedge clk);
        do_reset();
        predict(32'h100);
        check("post_rst_valid", obs_v, 1);
        check("post_rst_wnt", obs_t, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
